// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: the clear-engine
// state encoding, the default geometry and the address-width helper.
package regfile_pkg;

    // Bulk-clear engine states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Default geometry, matching the fixed 16 x 32 dual-read predecessor.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_NRD   = 2;

    // Address width for a given depth. The result is never below 1, so a
    // two-entry file still gets a real select bit.
    function automatic int calc_aw(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read lane of the register file.
// The lane selects an entry from the flattened storage and returns 0 for an
// address past the last entry. It can forward the write data of an accepted
// same-cycle write (enabled by BYPASS, driven from REGFILE_BYPASS_EN in the
// top). When en_i is low it holds its last value.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = calc_aw(DEF_DEPTH),
    parameter bit BYPASS = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic [AW-1:0]               sel_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
    input  logic                        byp_vld_i,
    input  logic [AW-1:0]               byp_sel_i,
    input  logic [WIDTH-1:0]            byp_data_i,
    output logic [WIDTH-1:0]            data_o
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rd_val;
    logic             in_range;
    logic             fwd;

    // Entry mux, written as a compare per entry. An address with no match
    // (past DEPTH-1) leaves rd_val at 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_i == AW'(i)) begin
                rd_val = mem_i[i];
            end
        end
    end

    // Range check and forwarding compare. byp_vld_i is only raised for
    // accepted writes, so a dropped write can never be forwarded.
    always_comb begin
        in_range = ({1'b0, sel_i} < DEPTH_L);
        fwd      = BYPASS && byp_vld_i && (byp_sel_i == sel_i);
    end

    // Next lane value: hold when disabled, 0 when out of range, otherwise
    // forwarded or stored data.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            if (!in_range) begin
                data_d = '0;
            end else if (fwd) begin
                data_d = byp_data_i;
            end else begin
                data_d = rd_val;
            end
        end
    end

    // Lane register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, NRD registered read ports and
// a sequential bulk-clear engine that zeroes one entry per cycle.
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write to
// any read port that selects the same entry at the same edge. Without it,
// such a read returns the pre-write contents.
module reg_file_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NRD   = DEF_NRD,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld,
    input  logic [AW-1:0]        wr_sel,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_sel,
    output logic [NRD*WIDTH-1:0] rd_data,
    input  logic                 clr,
    output logic                 busy,
    output logic                 wr_drop
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    clr_state_e                 state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic                       busy_q, busy_d;
    logic                       wr_drop_q, wr_drop_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    logic wr_in_range;
    logic wr_acc;

    // Write acceptance: blocked while sweeping, by a same-cycle clr (clr
    // wins) and by an address past the last entry. Any other ld is dropped
    // and reported on wr_drop the following cycle.
    always_comb begin
        wr_in_range = ({1'b0, wr_sel} < DEPTH_L);
        wr_acc      = ld && !busy_q && !clr && wr_in_range;
        wr_drop_d   = ld && !wr_acc;
    end

    // Clear engine next state. clr is only honoured from IDLE, so a
    // request during a sweep never restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Storage next state. An accepted write and a sweep step never coincide
    // because writes are blocked while busy.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_acc && (wr_sel == AW'(i))) begin
                mem_d[i] = wr_data;
            end
            if ((state_q == CLEAR) && (cnt_q == AW'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    // Clear engine and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Entry storage; reset (including mid-sweep) zeroes every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

    // One registered lane per read port, all looking at the same storage
    // and the same write port for forwarding.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_read_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .AW     (AW),
            .BYPASS (BYPASS_EN)
        ) u_rd (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .en_i       (rd_en[p]),
            .sel_i      (rd_sel[p*AW +: AW]),
            .mem_i      (mem_q),
            .byp_vld_i  (wr_acc),
            .byp_sel_i  (wr_sel),
            .byp_data_i (wr_data),
            .data_o     (rd_data[p*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a 16-entry instance (a_*) driven from
// a vector table plus hand-written clear/reset sequences, and a 12-entry
// instance (b_*) for the non-power-of-two range corner cases.
module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-entry instance
    logic        a_ld = 1'b0, a_clr = 1'b0;
    logic [3:0]  a_wsel = '0;
    logic [31:0] a_wdata = '0;
    logic [1:0]  a_rden = '0;
    logic [7:0]  a_rsel = '0;
    logic [63:0] a_rd;
    logic        a_busy, a_drop;

    // 12-entry instance
    logic        b_ld = 1'b0, b_clr = 1'b0;
    logic [3:0]  b_wsel = '0;
    logic [31:0] b_wdata = '0;
    logic [1:0]  b_rden = '0;
    logic [7:0]  b_rsel = '0;
    logic [63:0] b_rd;
    logic        b_busy, b_drop;

    reg_file_param #(.WIDTH(32), .DEPTH(16), .NRD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .ld(a_ld), .wr_sel(a_wsel), .wr_data(a_wdata),
        .rd_en(a_rden), .rd_sel(a_rsel), .rd_data(a_rd), .clr(a_clr),
        .busy(a_busy), .wr_drop(a_drop)
    );

    reg_file_param #(.WIDTH(32), .DEPTH(12), .NRD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ld(b_ld), .wr_sel(b_wsel), .wr_data(b_wdata),
        .rd_en(b_rden), .rd_sel(b_rsel), .rd_data(b_rd), .clr(b_clr),
        .busy(b_busy), .wr_drop(b_drop)
    );

    typedef struct {
        logic        ld;
        logic [3:0]  wsel;
        logic [31:0] wdata;
        logic [1:0]  rden;
        logic [3:0]  rs0;
        logic [3:0]  rs1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        edrop;
    } vec_t;

    vec_t vt[$];
    int   errors = 0;
    int   checks = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME_EDGE = 32'hDEADBEEF;
`else
    localparam logic [31:0] SAME_EDGE = 32'hFFFFFF05;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic ld, input logic [3:0] wsel,
                                 input logic [31:0] wdata, input logic [1:0] rden,
                                 input logic [3:0] rs0, input logic [3:0] rs1,
                                 input logic [31:0] e0, input logic [31:0] e1,
                                 input logic edrop);
        vec_t v;
        v.ld = ld; v.wsel = wsel; v.wdata = wdata; v.rden = rden;
        v.rs0 = rs0; v.rs1 = rs1; v.e0 = e0; v.e1 = e1; v.edrop = edrop;
        return v;
    endfunction

    initial begin
        int bcnt;

        // Table: fill 0..15, read back through both ports, hold, same-edge
        // write/read on entry 5, then the follow-up reads.
        for (int k = 0; k < 16; k++)
            vt.push_back(mkv(1'b1, 4'(k), 32'hFFFFFF00 + 32'(k), 2'b00, 4'd0, 4'd0,
                             32'h0, 32'h0, 1'b0));
        for (int k = 0; k < 16; k++)
            vt.push_back(mkv(1'b0, 4'd0, 32'h0, 2'b11, 4'(k), 4'(15 - k),
                             32'hFFFFFF00 + 32'(k), 32'hFFFFFF0F - 32'(k), 1'b0));
        vt.push_back(mkv(1'b0, 4'd0, 32'h0, 2'b00, 4'd3, 4'd4,
                         32'hFFFFFF0F, 32'hFFFFFF00, 1'b0));
        vt.push_back(mkv(1'b1, 4'd5, 32'hDEADBEEF, 2'b11, 4'd5, 4'd5,
                         SAME_EDGE, SAME_EDGE, 1'b0));
        vt.push_back(mkv(1'b0, 4'd0, 32'h0, 2'b01, 4'd5, 4'd0,
                         32'hDEADBEEF, SAME_EDGE, 1'b0));
        vt.push_back(mkv(1'b0, 4'd0, 32'h0, 2'b10, 4'd0, 4'd5,
                         32'hDEADBEEF, 32'hDEADBEEF, 1'b0));

        // Reset state
        #12;
        chk("reset a_rd0", a_rd[31:0], 32'h0);
        chk("reset a_rd1", a_rd[63:32], 32'h0);
        chk("reset a_busy", 32'(a_busy), 32'h0);
        chk("reset a_drop", 32'(a_drop), 32'h0);
        chk("reset b_busy", 32'(b_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (vt[i]) begin
            a_ld = vt[i].ld; a_wsel = vt[i].wsel; a_wdata = vt[i].wdata;
            a_rden = vt[i].rden; a_rsel = {vt[i].rs1, vt[i].rs0};
            step();
            chk($sformatf("vec%0d rd0", i), a_rd[31:0], vt[i].e0);
            chk($sformatf("vec%0d rd1", i), a_rd[63:32], vt[i].e1);
            chk($sformatf("vec%0d drop", i), 32'(a_drop), 32'(vt[i].edrop));
        end
        a_ld = 1'b0; a_rden = 2'b00;

        // Bulk clear: clr with ld at edge N, ld while busy at N+3, clr again
        // at N+8 (ignored), ld at N+16 (still busy), ld at N+17 (accepted).
        a_clr = 1'b1; a_ld = 1'b1; a_wsel = 4'd7; a_wdata = 32'h77777777;
        a_rden = 2'b11; a_rsel = {4'd15, 4'd0};
        step();
        chk("clr N busy", 32'(a_busy), 32'h1);
        chk("clr N drop", 32'(a_drop), 32'h1);
        chk("clr N rd0", a_rd[31:0], 32'hFFFFFF00);
        bcnt = 1;
        for (int j = 1; j <= 17; j++) begin
            a_clr = (j == 8);
            a_ld  = (j == 3) || (j == 16) || (j == 17);
            a_wsel  = (j == 3) ? 4'd3 : ((j == 16) ? 4'd10 : 4'd11);
            a_wdata = (j == 3) ? 32'h33333333 : ((j == 16) ? 32'hAAAAAAAA : 32'hBBBBBBBB);
            step();
            if (a_busy) bcnt++;
            chk($sformatf("clr N+%0d busy", j), 32'(a_busy), (j <= 15) ? 32'h1 : 32'h0);
            chk($sformatf("clr N+%0d drop", j), 32'(a_drop),
                ((j == 3) || (j == 16)) ? 32'h1 : 32'h0);
            chk($sformatf("clr N+%0d rd0", j), a_rd[31:0], (j >= 2) ? 32'h0 : 32'hFFFFFF00);
            chk($sformatf("clr N+%0d rd15", j), a_rd[63:32], (j >= 17) ? 32'h0 : 32'hFFFFFF0F);
        end
        chk("clr busy cycles", 32'(bcnt), 32'd16);
        a_ld = 1'b0; a_clr = 1'b0;
        a_rsel = {4'd7, 4'd3};
        step();
        chk("post clr e3", a_rd[31:0], 32'h0);
        chk("post clr e7", a_rd[63:32], 32'h0);
        a_rsel = {4'd11, 4'd10};
        step();
        chk("post clr e10", a_rd[31:0], 32'h0);
        chk("post clr e11", a_rd[63:32], 32'hBBBBBBBB);

        // Reset mid-clear: entries 9 and 12 hold data, sweep aborted at
        // cycle 6 before reaching them.
        a_rden = 2'b00;
        a_ld = 1'b1; a_wsel = 4'd9; a_wdata = 32'h99999999; step();
        a_wsel = 4'd12; a_wdata = 32'h12121212; step();
        a_ld = 1'b0; a_clr = 1'b1; step();
        a_clr = 1'b0;
        for (int j = 0; j < 5; j++) step();
        chk("pre rst busy", 32'(a_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", 32'(a_busy), 32'h0);
        chk("mid rst rd0", a_rd[31:0], 32'h0);
        chk("mid rst rd1", a_rd[63:32], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        a_rden = 2'b11;
        for (int k = 0; k < 8; k++) begin
            a_rsel = {4'(k + 8), 4'(k)};
            step();
            chk($sformatf("rst e%0d", k), a_rd[31:0], 32'h0);
            chk($sformatf("rst e%0d", k + 8), a_rd[63:32], 32'h0);
        end
        a_clr = 1'b1; step(); a_clr = 1'b0;
        bcnt = 0;
        for (int j = 0; j < 30; j++) begin
            if (a_busy) bcnt++;
            step();
        end
        chk("rst sweep busy cycles", 32'(bcnt), 32'd16);

        // DEPTH=12: out-of-range write/read, last valid entry, full sweep.
        b_ld = 1'b1; b_wsel = 4'd13; b_wdata = 32'h13131313; step();
        chk("b wr13 drop", 32'(b_drop), 32'h1);
        b_wsel = 4'd11; b_wdata = 32'h11111111; step();
        chk("b wr11 drop", 32'(b_drop), 32'h0);
        b_wsel = 4'd2; b_wdata = 32'h22222222; step();
        b_ld = 1'b0; b_rden = 2'b11; b_rsel = {4'd2, 4'd14}; step();
        chk("b rd14", b_rd[31:0], 32'h0);
        chk("b rd2", b_rd[63:32], 32'h22222222);
        b_rsel = {4'd13, 4'd11}; step();
        chk("b rd11", b_rd[31:0], 32'h11111111);
        chk("b rd13", b_rd[63:32], 32'h0);
        for (int k = 0; k < 6; k++) begin
            b_rsel = {4'(k + 6), 4'(k)};
            step();
            chk($sformatf("b e%0d", k), b_rd[31:0], (k == 2) ? 32'h22222222 : 32'h0);
            chk($sformatf("b e%0d", k + 6), b_rd[63:32], (k == 5) ? 32'h11111111 : 32'h0);
        end
        b_clr = 1'b1; step(); b_clr = 1'b0;
        bcnt = 0;
        for (int j = 0; j < 30; j++) begin
            if (b_busy) bcnt++;
            step();
        end
        chk("b sweep busy cycles", 32'(bcnt), 32'd12);
        b_rsel = {4'd2, 4'd11}; step();
        chk("b post clr e11", b_rd[31:0], 32'h0);
        chk("b post clr e2", b_rd[63:32], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
